dsc_mul_ctrl: RTL and testbench
===============================

Name: dsc_mul_ctrl

Overview:
Sequencer for the 3-input deterministic stochastic multiplier datapath. It accepts one operand triple over a valid/ready handshake and clears the datapath. It then enables the datapath for one full nested SNG sweep, waits for the final-stage overflow and latches the binary product. The product is presented over a valid/ready output handshake. It sits between the operand source and the datapath, and owns the datapath's enable and clear.

Parameters:
SNG_WIDTH, 8, operand width; the datapath product width is 3*SNG_WIDTH.
SLACK, 4, extra RUN cycles beyond 2^(3*SNG_WIDTH) before a timeout error is declared.
ZERO_BYPASS, 1, when 1, any zero operand skips the sweep and returns 0.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  operand triple valid.
in_ready  out  1  controller ready for an operand triple.
in_a, in_b, in_c  in  SNG_WIDTH each  operands.
abort  in  1  synchronous cancel of the current operation.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_z  out  3*SNG_WIDTH  product.
out_err  out  1  sweep timed out; qualified by out_valid.
busy  out  1  state is not IDLE.
dp_clr  out  1  one-cycle datapath clear pulse, active-high.
dp_en  out  1  datapath enable.
dp_a, dp_b, dp_c  out  SNG_WIDTH each  latched operands driven to the datapath.
dp_z  in  3*SNG_WIDTH  datapath result counter.
dp_ov  in  1  final-stage SNG overflow, one-cycle pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - dp_a/b/c=0, out_z=0, out_err=0, out_valid=0, dp_en=0, dp_clr=0, run_cnt=0.
  - in_ready=1 (in_ready is a decode of state==IDLE).
- States: IDLE, CLEAR, RUN, DRAIN, DONE. All transitions occur on the rising edge of clk.
- IDLE:
  - in_ready=1.
  - in_valid=1 accepts and latches dp_a/b/c on that edge.
  - If ZERO_BYPASS=1 and any operand is 0: go to DONE with out_z=0, out_err=0.
  - Otherwise: go to CLEAR.
- CLEAR:
  - dp_clr=1, dp_en=0 for exactly one cycle; run_cnt cleared.
  - Next state RUN.
- RUN:
  - dp_en=1; run_cnt increments every cycle (width 3*SNG_WIDTH+1).
  - dp_ov=1: go to DRAIN.
  - run_cnt reaching 2^(3*SNG_WIDTH)+SLACK without dp_ov: go to DRAIN with out_err set to 1.
  - If dp_ov and the timeout coincide, dp_ov wins and out_err=0.
- DRAIN:
  - dp_en=0 for one cycle so the final increment of the result counter settles.
  - out_z captured from dp_z at the end of DRAIN.
  - Next state DONE.
- DONE:
  - out_valid=1; out_z and out_err held stable.
  - out_ready=1: out_valid falls on the next edge and state goes to IDLE.
  - No new operand is accepted in the same cycle as the result handshake.
- Latency, no bypass: accept edge T, CLEAR T+1, first RUN T+2. Nominal RUN length is 2^(3*SNG_WIDTH) cycles. out_valid rises two cycles after dp_ov.
- Bypass latency: out_valid rises one cycle after accept.
- abort=1:
  - In CLEAR, RUN, DRAIN or DONE: state goes to IDLE on the next edge; dp_en drops, out_valid drops, and no result is issued.
  - In IDLE: ignored; a simultaneous in_valid is accepted normally.
  - abort is sampled before dp_ov and the timeout.
- Operands are held constant on dp_a/b/c from accept until the next accept; the outputs are never glitched mid-sweep.
- dp_ov outside RUN is ignored.
- Asserting rst mid-sweep clears everything immediately; the datapath is cleared by the next CLEAR.

Decomposition:
- Shared package dsc_pkg holds:
  - SNG_WIDTH default and derived PROD_WIDTH = 3*SNG_WIDTH.
  - State encoding constants (IDLE=0, CLEAR=1, RUN=2, DRAIN=3, DONE=4).
  - SLACK default.
- One natural sub-module: run_cnt is an instance of the existing counter module with WIDTH = 3*SNG_WIDTH+1. Enable is state==RUN; clear is dp_clr.
- The FSM and handshake logic stay in dsc_mul_ctrl.

Test Plan:
Benches use SNG_WIDTH=2 (64-cycle sweep) with a behavioural datapath model: dp_ov pulses on the 64th dp_en cycle and dp_z equals the count of enabled cycles where all three unary streams are 1.
- Nominal product: a=3, b=2, c=1 with out_ready held 1 -> exactly one dp_clr pulse, dp_en high 64 cycles, out_z=6, out_err=0, out_valid rises 2 cycles after dp_ov.
- Zero bypass: a=0, b=3, c=3 -> dp_en never asserted, out_valid one cycle after accept, out_z=0; with ZERO_BYPASS=0 -> full 64-cycle sweep, out_z=0.
- Timeout: model never pulses dp_ov -> RUN lasts 68 cycles (64+SLACK), then out_err=1 with out_valid.
- Coincident events: dp_ov asserted on the timeout cycle -> out_err=0.
- Backpressure: out_ready=0 for 10 cycles -> out_valid and out_z=6 held stable, in_ready=0; result accepted on the first out_ready=1, then in_ready=1 next cycle.
- Abort and reset: abort at RUN cycle 20 -> IDLE next cycle, no out_valid, a following triple (3,3,3) returns out_z=27. rst=0 mid-RUN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/dsc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsc_pkg
// Description : Shared types and defaults for the deterministic stochastic
//               multiplier controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dsc_pkg;

    localparam int SNG_WIDTH_DEF  = 8;
    localparam int PROD_WIDTH_DEF = 3 * SNG_WIDTH_DEF;
    localparam int SLACK_DEF      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Product width of a three-operand multiply of w-bit operands.
    function automatic int prod_width(input int w);
        return 3 * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsc_mul_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dsc_mul_ctrl_if
// Description : Operand and result handshakes between the operand source /
//               result consumer (master) and the multiplier controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dsc_mul_ctrl_if
    import dsc_pkg::*;
#(
    parameter int SNG_WIDTH = SNG_WIDTH_DEF
);
    logic                       in_valid;
    logic                       in_ready;
    logic [SNG_WIDTH-1:0]       in_a;
    logic [SNG_WIDTH-1:0]       in_b;
    logic [SNG_WIDTH-1:0]       in_c;
    logic                       abort;
    logic                       out_valid;
    logic                       out_ready;
    logic [3*SNG_WIDTH-1:0]     out_z;
    logic                       out_err;

    modport master (
        output in_valid, in_a, in_b, in_c, abort, out_ready,
        input  in_ready, out_valid, out_z, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, abort, out_ready,
        output in_ready, out_valid, out_z, out_err
    );
endinterface
`default_nettype wire

// File: rtl/dsc_mul_ctrl_counter.sv
`default_nettype none
// ============================================================================
// Module      : dsc_mul_ctrl_counter
// Description : Free-running up counter with synchronous clear (priority over
//               enable) and asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dsc_mul_ctrl_counter #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles; clear wins over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dsc_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dsc_mul_ctrl
// Description : Sequencer for the 3-input deterministic stochastic multiplier.
//               Accepts an operand triple, clears and runs the datapath for one
//               nested SNG sweep, captures the product and returns it.
// Revision    : 1.0 - initial release
// ============================================================================
module dsc_mul_ctrl
    import dsc_pkg::*;
#(
    parameter int SNG_WIDTH   = SNG_WIDTH_DEF,
    parameter int SLACK       = SLACK_DEF,
    parameter int ZERO_BYPASS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    dsc_mul_ctrl_if.slave                host,
    output logic                         busy,
    output logic                         dp_clr,
    output logic                         dp_en,
    output logic [SNG_WIDTH-1:0]         dp_a,
    output logic [SNG_WIDTH-1:0]         dp_b,
    output logic [SNG_WIDTH-1:0]         dp_c,
    input  logic [3*SNG_WIDTH-1:0]       dp_z,
    input  logic                         dp_ov
);

    localparam int PROD_WIDTH = prod_width(SNG_WIDTH);
    localparam int CNT_WIDTH  = PROD_WIDTH + 1;
    localparam bit BYPASS_EN  = (ZERO_BYPASS != 0);
    // Value of the run counter during the last permitted RUN cycle; the
    // counter holds (cycles already spent in RUN), so this is LIMIT-1.
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST =
        CNT_WIDTH'((64'd1 << PROD_WIDTH) + 64'(SLACK) - 64'd1);

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_accept;
    logic                    w_bypass;
    logic                    w_any_zero;
    logic                    w_timeout;
    logic                    w_run_en;
    logic [CNT_WIDTH-1:0]    w_run_cnt;

    logic [SNG_WIDTH-1:0]    r_dp_a;
    logic [SNG_WIDTH-1:0]    r_dp_b;
    logic [SNG_WIDTH-1:0]    r_dp_c;
    logic                    r_dp_en;
    logic                    r_dp_clr;
    logic                    r_out_valid;
    logic [PROD_WIDTH-1:0]   r_out_z;
    logic                    r_out_err;

    assign w_any_zero = (host.in_a == '0) || (host.in_b == '0) || (host.in_c == '0);
    assign w_timeout  = (w_run_cnt == TIMEOUT_LAST);
    assign w_run_en   = (r_state == ST_RUN);

    // Cycles spent in RUN; cleared by the same pulse that clears the datapath.
    dsc_mul_ctrl_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_run_en),
        .clr   (r_dp_clr),
        .count (w_run_cnt)
    );

    // Next-state decode; abort outranks dp_ov, which outranks the timeout.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_bypass = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (host.in_valid) begin
                    w_accept = 1'b1;
                    if (BYPASS_EN && w_any_zero) begin
                        w_bypass = 1'b1;
                        w_next   = ST_DONE;
                    end else begin
                        w_next   = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                w_next = host.abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (host.abort) begin
                    w_next = ST_IDLE;
                end else if (dp_ov || w_timeout) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_next = host.abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (host.abort || host.out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered datapath controls, operand latch and result capture; controls
    // are decoded from the next state so they are glitch-free flop outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dp_a      <= '0;
            r_dp_b      <= '0;
            r_dp_c      <= '0;
            r_dp_en     <= 1'b0;
            r_dp_clr    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_z     <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_dp_clr    <= (w_next == ST_CLEAR);
            r_dp_en     <= (w_next == ST_RUN);
            r_out_valid <= (w_next == ST_DONE);
            if (w_accept) begin
                r_dp_a    <= host.in_a;
                r_dp_b    <= host.in_b;
                r_dp_c    <= host.in_c;
                r_out_err <= 1'b0;
            end
            if (w_bypass) begin
                r_out_z <= '0;
            end
            if ((r_state == ST_RUN) && !host.abort && !dp_ov && w_timeout) begin
                r_out_err <= 1'b1;
            end
            if ((r_state == ST_DRAIN) && !host.abort) begin
                r_out_z <= dp_z;
            end
        end
    end

    assign host.in_ready  = (r_state == ST_IDLE);
    assign host.out_valid = r_out_valid;
    assign host.out_z     = r_out_z;
    assign host.out_err   = r_out_err;
    assign busy           = (r_state != ST_IDLE);
    assign dp_clr         = r_dp_clr;
    assign dp_en          = r_dp_en;
    assign dp_a           = r_dp_a;
    assign dp_b           = r_dp_b;
    assign dp_c           = r_dp_c;

endmodule
`default_nettype wire

// File: tb/tb_dsc_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsc_mul_ctrl
// Description : Scoreboard bench for dsc_mul_ctrl with a behavioural
//               nested-SNG datapath model (SNG_WIDTH=2, 64-cycle sweep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsc_mul_ctrl;

    localparam int W      = 2;
    localparam int PW     = 3 * W;
    localparam int NSWEEP = 64;
    localparam int SLK    = 4;

    typedef struct {
        int z;
        bit err;
        bit chkz;
        int en;
        int clr;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dsc_mul_ctrl_if #(.SNG_WIDTH(W)) hif ();
    dsc_mul_ctrl_if #(.SNG_WIDTH(W)) nif ();

    logic          busy, dp_clr, dp_en, dp_ov;
    logic [W-1:0]  dp_a, dp_b, dp_c;
    logic [PW-1:0] dp_z;
    logic          n_busy, n_dp_clr, n_dp_en, n_dp_ov;
    logic [W-1:0]  n_dp_a, n_dp_b, n_dp_c;
    logic [PW-1:0] n_dp_z;

    dsc_mul_ctrl #(.SNG_WIDTH(W), .SLACK(SLK), .ZERO_BYPASS(1)) dut (
        .clk(clk), .rst(rst), .host(hif), .busy(busy), .dp_clr(dp_clr), .dp_en(dp_en),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_z(dp_z), .dp_ov(dp_ov)
    );

    dsc_mul_ctrl #(.SNG_WIDTH(W), .SLACK(SLK), .ZERO_BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .host(nif), .busy(n_busy), .dp_clr(n_dp_clr), .dp_en(n_dp_en),
        .dp_a(n_dp_a), .dp_b(n_dp_b), .dp_c(n_dp_c), .dp_z(n_dp_z), .dp_ov(n_dp_ov)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Nested SNG unary streams: a on the low digit, b on the middle, c on top.
    function automatic bit ustream(input int i, input int a, input int b, input int c);
        return ((i % 4) < a) && (((i / 4) % 4) < b) && (((i / 16) % 4) < c);
    endfunction

    // Datapath model for the bypass-enabled DUT. ov_mode: 0 pulse on the 64th
    // enabled cycle, 1 never, 2 pulse on the 68th (the timeout cycle).
    int            ov_mode = 0;
    int            m_cnt   = 0;
    logic [PW-1:0] m_z     = '0;
    always @(posedge clk) begin
        if (dp_clr) begin
            m_cnt <= 0;
            m_z   <= '0;
        end else if (dp_en) begin
            m_cnt <= m_cnt + 1;
            if (ustream(m_cnt, int'(dp_a), int'(dp_b), int'(dp_c))) m_z <= m_z + 6'd1;
        end
    end
    assign dp_z  = m_z;
    assign dp_ov = dp_en && ((ov_mode == 0 && m_cnt == NSWEEP - 1) ||
                             (ov_mode == 2 && m_cnt == NSWEEP + SLK - 1));

    // Datapath model for the bypass-disabled DUT (always nominal).
    int            n_cnt = 0;
    logic [PW-1:0] n_zr  = '0;
    always @(posedge clk) begin
        if (n_dp_clr) begin
            n_cnt <= 0;
            n_zr  <= '0;
        end else if (n_dp_en) begin
            n_cnt <= n_cnt + 1;
            if (ustream(n_cnt, int'(n_dp_a), int'(n_dp_b), int'(n_dp_c))) n_zr <= n_zr + 6'd1;
        end
    end
    assign n_dp_z  = n_zr;
    assign n_dp_ov = n_dp_en && (n_cnt == NSWEEP - 1);

    // Reference: product, error and timing from the operation's rules.
    function automatic exp_t model(input int a, input int b, input int c);
        exp_t e;
        int   run;
        if (a == 0 || b == 0 || c == 0) begin
            e.z = 0; e.err = 1'b0; e.chkz = 1'b1; e.en = 0; e.clr = 0; e.lat = 1;
        end else begin
            run    = (ov_mode == 0) ? NSWEEP : NSWEEP + SLK;
            e.z    = a * b * c;
            e.err  = (ov_mode == 1);
            e.chkz = (ov_mode == 0);
            e.en   = run;
            e.clr  = 1;
            e.lat  = run + 3;   // CLEAR + RUN + DRAIN, then DONE is visible
        end
        return e;
    endfunction

    exp_t sbq[$];

    // Monitor: tracks accept/valid timing and pops the scoreboard on each
    // result handshake.
    int cyc = 0, acc_cyc = 0, rise_cyc = 0, ov_cyc = 0, en_seen = 0, clr_seen = 0;
    bit pv = 1'b0, ov_seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            pv      = 1'b0;
            ov_seen = 1'b0;
        end else begin
            if (dp_en)  en_seen++;
            if (dp_clr) clr_seen++;
            if (dp_ov) begin
                ov_seen = 1'b1;
                ov_cyc  = cyc;
            end
            if (hif.out_valid && !pv) begin
                rise_cyc = cyc;
                if (ov_seen) chk("ov_to_valid", rise_cyc - ov_cyc, 2);
            end
            pv = hif.out_valid;
            if (hif.out_valid && hif.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    if (e.chkz) chk("out_z", int'(hif.out_z), e.z);
                    chk("out_err", int'(hif.out_err), int'(e.err));
                    chk("dp_en_cycles", en_seen, e.en);
                    chk("dp_clr_pulses", clr_seen, e.clr);
                    chk("latency", rise_cyc - acc_cyc, e.lat);
                end
            end
            if (hif.in_valid && hif.in_ready) begin
                acc_cyc  = cyc;
                en_seen  = 0;
                clr_seen = 0;
                ov_seen  = 1'b0;
            end
        end
    end

    // out_ready driver: 0 hold high, 1 random, 2 hold low.
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        hif.out_ready = (rdy_mode == 0) ? 1'b1 :
                        (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic send(input int a, input int b, input int c, input bit push);
        bit ok = 1'b0;
        @(posedge clk); #1;
        hif.in_a     = W'(a);
        hif.in_b     = W'(b);
        hif.in_c     = W'(c);
        hif.in_valid = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (hif.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        else if (push) sbq.push_back(model(a, b, c));
        @(posedge clk); #1;
        hif.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_en_cycles(input int n);
        int k = 0;
        for (int t = 0; t < 400 && k < n; t++) begin
            @(negedge clk);
            if (dp_en) k++;
        end
        if (k != n) chk("run_wait_timeout", k, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(hif.in_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_dp_en"}, int'(dp_en), 0);
        chk({tag, "_dp_clr"}, int'(dp_clr), 0);
        chk({tag, "_out_valid"}, int'(hif.out_valid), 0);
        chk({tag, "_out_z"}, int'(hif.out_z), 0);
        chk({tag, "_out_err"}, int'(hif.out_err), 0);
        chk({tag, "_dp_a"}, int'(dp_a), 0);
    endtask

    initial begin
        int nen;
        bit ok;
        hif.in_valid = 1'b0; hif.in_a = '0; hif.in_b = '0; hif.in_c = '0;
        hif.abort = 1'b0; hif.out_ready = 1'b1;
        nif.in_valid = 1'b0; nif.in_a = '0; nif.in_b = '0; nif.in_c = '0;
        nif.abort = 1'b0; nif.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Nominal product and zero bypass.
        send(3, 2, 1, 1'b1);
        wait_drain();
        send(0, 3, 3, 1'b1);
        wait_drain();

        // Zero operand without bypass runs the full sweep.
        @(posedge clk); #1;
        nif.in_a = 2'd0; nif.in_b = 2'd3; nif.in_c = 2'd3; nif.in_valid = 1'b1;
        @(posedge clk); #1;
        nif.in_valid = 1'b0;
        nen = 0; ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (n_dp_en) nen++;
            if (nif.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("nb_done", int'(ok), 1);
        chk("nb_en_cycles", nen, NSWEEP);
        chk("nb_out_z", int'(nif.out_z), 0);
        chk("nb_out_err", int'(nif.out_err), 0);
        @(negedge clk);

        // Timeout, then dp_ov coinciding with the timeout cycle.
        ov_mode = 1;
        send(2, 2, 2, 1'b1);
        wait_drain();
        ov_mode = 2;
        send(1, 1, 1, 1'b1);
        wait_drain();
        ov_mode = 0;

        // Backpressure: result held for 10 cycles, then accepted.
        rdy_mode = 2;
        send(3, 2, 1, 1'b1);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (hif.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_valid_seen", int'(ok), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(hif.out_valid), 1);
            chk("bp_hold_z", int'(hif.out_z), 6);
            chk("bp_hold_in_ready", int'(hif.in_ready), 0);
        end
        rdy_mode = 0;
        @(negedge clk);
        chk("bp_handshake", int'(hif.out_valid && hif.out_ready), 1);
        @(negedge clk);
        chk("bp_in_ready_after", int'(hif.in_ready), 1);
        chk("bp_valid_after", int'(hif.out_valid), 0);

        // Abort at RUN cycle 20: no result, operands held, next op correct.
        send(1, 2, 3, 1'b0);
        wait_en_cycles(20);
        hif.abort = 1'b1;
        @(posedge clk); #1;
        hif.abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(hif.in_ready), 1);
        chk("abort_dp_en", int'(dp_en), 0);
        chk("abort_out_valid", int'(hif.out_valid), 0);
        chk("abort_hold_a", int'(dp_a), 1);
        repeat (80) @(negedge clk);
        send(3, 3, 3, 1'b1);
        wait_drain();

        // Asynchronous reset mid-RUN.
        send(3, 2, 1, 1'b0);
        wait_en_cycles(10);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        @(negedge clk);
        rst = 1'b1;

        // Randomized triples with random result backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 12; i++) begin
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'b1);
        end
        wait_drain();
        rdy_mode = 0;
        chk("scoreboard_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
